// File: rtl/bf16_pkg.sv
// -----------------------------------------------------------------------------
// bf16_pkg
// Shared definitions for the BF16 result-drain path: operand/result widths,
// the canonical +0.0 encoding and the drain scheduler state encoding.
// -----------------------------------------------------------------------------
package bf16_pkg;

    localparam int SINT_W = 23;
    localparam int BF16_W = 16;

    localparam logic [BF16_W-1:0] BF16_POS_ZERO = 16'h0000;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : bf16_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search: picks the first requesting lane
// starting at ptr and wrapping around.
// Ports:
//   req    in  NUM_LANES   request vector
//   ptr    in  ID_W        lane that has highest priority this cycle
//   grant  out NUM_LANES   one-hot grant (zero when no request)
//   idx    out ID_W        index of the granted lane (zero when no request)
//   any    out 1           at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int ID_W      = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [ID_W-1:0]      idx,
    output logic                 any
);

    logic found_s;
    int   lane_s;

    // circular priority search from ptr; the first hit wins
    always_comb begin
        grant   = {NUM_LANES{1'b0}};
        idx     = {ID_W{1'b0}};
        found_s = 1'b0;
        lane_s  = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_s = int'(ptr) + k;
            if (lane_s >= NUM_LANES) begin
                lane_s = lane_s - NUM_LANES;
            end else begin
                lane_s = lane_s;
            end
            if (!found_s && req[lane_s]) begin
                found_s        = 1'b1;
                grant[lane_s]  = 1'b1;
                idx            = ID_W'(lane_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule : rr_arbiter

// File: rtl/bf16_drain_scheduler.sv
// -----------------------------------------------------------------------------
// bf16_drain_scheduler
// Shares one external Sint23ToBF16 converter among NUM_LANES accumulator lanes
// during result drain. Lanes are granted round-robin; the granted operand is
// driven to the converter with cvt_en for one cycle and the (registered)
// converter result is presented the next cycle on a valid/ready output with
// its lane id. The converter maps 0 to 0x0001, which is patched to +0.0 here.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/data    per-lane operand requests (lane i at [i*IN_W +: IN_W])
//   req_ready         one-hot accept strobe, zero when not issuing
//   cvt_en/in/out     converter enable, operand and registered result
//   out_valid/data/lane/ready  result stream with producing lane id
//   busy              result held or any lane requesting
//   done_count        count of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module bf16_drain_scheduler
    import bf16_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_W      = SINT_W,
    parameter int ID_W      = $clog2(NUM_LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_LANES-1:0]      req_valid,
    input  logic [NUM_LANES*IN_W-1:0] req_data,
    output logic [NUM_LANES-1:0]      req_ready,
    output logic                      cvt_en,
    output logic [IN_W-1:0]           cvt_in,
    input  logic [BF16_W-1:0]         cvt_out,
    output logic                      out_valid,
    output logic [BF16_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_lane,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [15:0]               done_count
);

    state_t                 state_r;
    logic                   zero_flag_r;
    logic [ID_W-1:0]        rr_ptr_r;

    logic [NUM_LANES-1:0]   grant_s;
    logic [ID_W-1:0]        gnt_idx_s;
    logic                   any_s;
    logic                   issue_s;
    logic                   handshake_s;
    logic [IN_W-1:0]        sel_data_s;
    logic [ID_W-1:0]        next_ptr_s;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .ID_W      (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (gnt_idx_s),
        .any   (any_s)
    );

    assign out_valid   = (state_r == HOLD);
    assign handshake_s = out_valid & out_ready;
    // masked during reset so the accept strobe and busy read zero immediately
    assign issue_s     = ~rst & any_s & ((state_r == IDLE) | out_ready);
    assign sel_data_s  = req_data[gnt_idx_s*IN_W +: IN_W];
    assign next_ptr_s  = (gnt_idx_s == ID_W'(NUM_LANES - 1)) ? {ID_W{1'b0}}
                                                              : gnt_idx_s + ID_W'(1);
    assign busy        = ~rst & (out_valid | (|req_valid));

    // converter sequencing: operand only while issuing so the converter holds otherwise
    always_comb begin
        req_ready = {NUM_LANES{1'b0}};
        cvt_en    = 1'b0;
        cvt_in    = {IN_W{1'b0}};
        if (issue_s) begin
            req_ready = grant_s;
            cvt_en    = 1'b1;
            cvt_in    = sel_data_s;
        end else begin
            req_ready = {NUM_LANES{1'b0}};
            cvt_en    = 1'b0;
            cvt_in    = {IN_W{1'b0}};
        end
    end

    // result mux: converter output with zero patch, forced to zero when not valid
    always_comb begin
        out_data = BF16_POS_ZERO;
        if (out_valid && !zero_flag_r) begin
            out_data = cvt_out;
        end else begin
            out_data = BF16_POS_ZERO;
        end
    end

    // scheduler state, lane tag, zero patch flag, pointer and handshake counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            zero_flag_r <= 1'b0;
            rr_ptr_r    <= {ID_W{1'b0}};
            out_lane    <= {ID_W{1'b0}};
            done_count  <= 16'd0;
        end else begin
            if (handshake_s) begin
                done_count <= done_count + 16'd1;
            end
            if (issue_s) begin
                state_r     <= HOLD;
                out_lane    <= gnt_idx_s;
                zero_flag_r <= (sel_data_s == {IN_W{1'b0}});
                rr_ptr_r    <= next_ptr_s;
            end else if (handshake_s) begin
                state_r <= IDLE;
            end
        end
    end

endmodule : bf16_drain_scheduler
